// File: rtl/i2c_controller_if.sv
// i2c_controller_if: host command/data handshake and open-drain pad signals of the I2C controller
interface i2c_controller_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [6:0] cmd_addr;
   logic       cmd_rw;
   logic [3:0] cmd_len;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       scl_oe;
   logic       sda_oe;
   logic       sda_in;
   logic       scl_in;
   logic       busy;
   logic       done;
   logic       nack;
   modport master (
      output cmd_valid, cmd_addr, cmd_rw, cmd_len, wr_data, wr_valid, sda_in, scl_in,
      input  cmd_ready, wr_ready, rd_data, rd_valid, scl_oe, sda_oe, busy, done, nack
   );
   modport slave (
      input  cmd_valid, cmd_addr, cmd_rw, cmd_len, wr_data, wr_valid, sda_in, scl_in,
      output cmd_ready, wr_ready, rd_data, rd_valid, scl_oe, sda_oe, busy, done, nack
   );
endinterface

// File: rtl/i2c_controller.sv
// i2c_controller: byte-level I2C initiator (START, address+R/W, data bytes with ACK, STOP) on open-drain enables
// Optional responder clock stretching is enabled by defining I2C_CLOCK_STRETCH_EN.
module i2c_controller #(
   parameter int QUARTER = 8
) (
   input  logic            clk,
   input  logic            reset,
   i2c_controller_if.slave bus
);
   localparam int QW = $clog2(QUARTER);
   typedef enum logic [3:0] {IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, RACK, STOP} state_t;
   state_t        state_q, state_d;
   logic [QW-1:0] qcnt_q, qcnt_d;
   logic [1:0]    qph_q, qph_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    sh_q, sh_d, rd_data_q, rd_data_d;
   logic [3:0]    len_q, len_d;
   logic          rw_q, rw_d, wait_q, wait_d, samp_q, samp_d;
   logic          scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
   logic          rd_valid_q, rd_valid_d, wr_ready_q, wr_ready_d, done_q, done_d;
   logic          nack_q, nack_d, busy_q, busy_d, cmd_ready_q, cmd_ready_d;
   logic [1:0]    sda_s_q;
   logic          qend, hold, wr_req, go_stop;

   assign qend = qcnt_q == QW'(QUARTER - 1);

`ifdef I2C_CLOCK_STRETCH_EN
   logic [1:0] scl_s_q;
   // Synchronize the SCL pad so a stretching responder can be observed
   always_ff @(posedge clk) scl_s_q <= reset ? 2'b11 : {scl_s_q[0], bus.scl_in};
   // The first two clocks of q2 still show our own low drive through the synchronizer, so they never hold
   assign hold = qph_q[1] && !scl_s_q[1] && !(qph_q == 2'd2 && qcnt_q <= QW'(1));
`else
   assign hold = 1'b0;
`endif

   // Next-state: quarter timing, bit/byte sequencing and the pad levels for the coming quarter
   always_comb begin
      state_d = state_q; qcnt_d = qcnt_q; qph_d = qph_q; bit_d = bit_q; sh_d = sh_q;
      len_d = len_q; rw_d = rw_q; wait_d = wait_q; samp_d = samp_q;
      scl_oe_d = scl_oe_q; sda_oe_d = sda_oe_q; rd_data_d = rd_data_q; rd_valid_d = 1'b0;
      wr_ready_d = 1'b0; done_d = 1'b0; nack_d = nack_q; busy_d = busy_q; cmd_ready_d = cmd_ready_q;
      wr_req = 1'b0; go_stop = 1'b0;
      if (state_q == IDLE) begin
         if (bus.cmd_valid && cmd_ready_q) begin
            state_d = START; qph_d = 2'd0; qcnt_d = '0;
            sh_d = {bus.cmd_addr, bus.cmd_rw}; len_d = bus.cmd_len; rw_d = bus.cmd_rw;
            nack_d = 1'b0; busy_d = 1'b1; cmd_ready_d = 1'b0;
         end
      end else if (wait_q) begin
         wr_req = 1'b1;
      end else if (!hold) begin
         qcnt_d = qend ? '0 : qcnt_q + 1'b1;
         if (qend) begin
            qph_d = qph_q + 2'd1;
            if (qph_q == 2'd2) begin
               samp_d = sda_s_q[1];
               if (state_q == RDATA) begin
                  sh_d = {sh_q[6:0], sda_s_q[1]};
                  rd_valid_d = bit_q == 3'd0;
                  rd_data_d = bit_q == 3'd0 ? {sh_q[6:0], sda_s_q[1]} : rd_data_q;
               end
            end
            if (qph_q == 2'd1) begin
               sda_oe_d = state_q == START ? 1'b1 : sda_oe_q;
               scl_oe_d = state_q == START ? scl_oe_q : 1'b0;
            end else if (qph_q == 2'd2) begin
               scl_oe_d = state_q == START ? 1'b1 : scl_oe_q;
               sda_oe_d = state_q == STOP ? 1'b0 : sda_oe_q;
            end else if (qph_q == 2'd3) begin
               scl_oe_d = 1'b1;
               case (state_q)
                  START: begin
                     state_d = ADDR; bit_d = 3'd7; sda_oe_d = ~sh_q[7];
                  end
                  ADDR, WDATA: begin
                     if (bit_q != 3'd0) begin
                        bit_d = bit_q - 3'd1; sh_d = {sh_q[6:0], 1'b0}; sda_oe_d = ~sh_q[6];
                     end else begin
                        state_d = state_q == ADDR ? AACK : WACK; sda_oe_d = 1'b0;
                     end
                  end
                  RDATA: begin
                     if (bit_q != 3'd0) bit_d = bit_q - 3'd1;
                     else begin
                        state_d = RACK; sda_oe_d = len_q != 4'd1;
                     end
                  end
                  AACK: begin
                     nack_d = nack_q | samp_q;
                     go_stop = samp_q || len_q == 4'd0;
                     wr_req = !go_stop && !rw_q;
                     if (!go_stop && rw_q) begin
                        state_d = RDATA; bit_d = 3'd7; sda_oe_d = 1'b0;
                     end
                  end
                  WACK: begin
                     len_d = len_q - 4'd1; nack_d = nack_q | samp_q;
                     go_stop = samp_q || len_q == 4'd1;
                     wr_req = !go_stop;
                  end
                  RACK: begin
                     len_d = len_q - 4'd1;
                     go_stop = len_q == 4'd1;
                     if (!go_stop) begin
                        state_d = RDATA; bit_d = 3'd7; sda_oe_d = 1'b0;
                     end
                  end
                  STOP: begin
                     state_d = IDLE; scl_oe_d = 1'b0; sda_oe_d = 1'b0;
                     done_d = 1'b1; busy_d = 1'b0; cmd_ready_d = 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
      if (go_stop) begin
         state_d = STOP; scl_oe_d = 1'b1; sda_oe_d = 1'b1;
      end
      // Entering a write byte stalls in q0 with SCL low until the host offers data
      if (wr_req) begin
         state_d = WDATA; qph_d = 2'd0; qcnt_d = '0; bit_d = 3'd7; scl_oe_d = 1'b1;
         wait_d = !bus.wr_valid; wr_ready_d = bus.wr_valid;
         sh_d = bus.wr_valid ? bus.wr_data : sh_q;
         sda_oe_d = bus.wr_valid ? ~bus.wr_data[7] : 1'b0;
      end
   end

   // State, datapath and registered outputs; SDA synchronizer shares the same clocked block
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE; qcnt_q <= '0; qph_q <= 2'd0; bit_q <= 3'd0; sh_q <= 8'd0;
         len_q <= 4'd0; rw_q <= 1'b0; wait_q <= 1'b0; samp_q <= 1'b1;
         scl_oe_q <= 1'b0; sda_oe_q <= 1'b0; rd_data_q <= 8'd0; rd_valid_q <= 1'b0;
         wr_ready_q <= 1'b0; done_q <= 1'b0; nack_q <= 1'b0; busy_q <= 1'b0;
         cmd_ready_q <= 1'b1; sda_s_q <= 2'b11;
      end else begin
         state_q <= state_d; qcnt_q <= qcnt_d; qph_q <= qph_d; bit_q <= bit_d; sh_q <= sh_d;
         len_q <= len_d; rw_q <= rw_d; wait_q <= wait_d; samp_q <= samp_d;
         scl_oe_q <= scl_oe_d; sda_oe_q <= sda_oe_d; rd_data_q <= rd_data_d; rd_valid_q <= rd_valid_d;
         wr_ready_q <= wr_ready_d; done_q <= done_d; nack_q <= nack_d; busy_q <= busy_d;
         cmd_ready_q <= cmd_ready_d; sda_s_q <= {sda_s_q[0], bus.sda_in};
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.wr_ready  = wr_ready_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.scl_oe    = scl_oe_q;
   assign bus.sda_oe    = sda_oe_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.nack      = nack_q;
endmodule

// File: tb/tb_i2c_controller.sv
// tb_i2c_controller: directed bench for the I2C controller with a bus-level responder model
module tb_i2c_controller;
   localparam int Q = 8;
   logic clk = 1'b0;
   logic reset = 1'b1;
   i2c_controller_if bus();
   i2c_controller #(.QUARTER(Q)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   logic resp_low = 1'b0, resp_ack = 1'b0, stretch = 1'b0;
   int resp_n = 0;
   logic [7:0] rbuf [0:15];
   logic [7:0] wbuf [0:15];
   logic [7:0] rd_got [0:15];
   logic [7:0] mon_byte [0:16];
   logic mon_ack [0:16];
   int slot = 0, rd_cnt = 0, wr_cnt = 0, lat = 0, scl_rel = 0, done_cnt = 0;
   logic mid_ready, mid_busy;
   logic prev_scl = 1'b1, prev_sda = 1'b1;
   logic scl_line, sda_line;
   assign scl_line = ~bus.scl_oe;
   assign sda_line = ~bus.sda_oe & ~resp_low;
   assign bus.sda_in = sda_line;
   assign bus.scl_in = scl_line & ~stretch;

   // Responder: tracks START and SCL edges, records bits, drives ACK/read data after SCL falls
   always @(negedge clk) begin
      int b, p;
      logic cs, cd;
      cs = scl_line; cd = sda_line;
      if (prev_scl === 1'b1 && cs === 1'b1 && prev_sda === 1'b1 && cd === 1'b0) slot = 0;
      else if (prev_scl === 1'b0 && cs === 1'b1) begin
         b = slot / 9; p = slot % 9;
         if (b <= 16) begin
            if (p < 8) mon_byte[b] = {mon_byte[b][6:0], cd};
            else mon_ack[b] = cd;
         end
         slot++;
      end else if (prev_scl === 1'b1 && cs === 1'b0) begin
         b = slot / 9; p = slot % 9;
         resp_low = (b == 0) ? (p == 8 && resp_ack)
                  : (b > resp_n) ? 1'b0
                  : mon_byte[0][0] ? (p < 8 && !rbuf[b-1][7-p])
                  : (p == 8 && resp_ack);
      end
      prev_scl = cs; prev_sda = cd;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic do_cmd(input logic [6:0] a, input logic rw, input logic [3:0] len,
                         input int wr_from, input int st_from);
      int wi = 0;
      rd_cnt = 0; wr_cnt = 0; scl_rel = 0;
      bus.cmd_addr = a; bus.cmd_rw = rw; bus.cmd_len = len; bus.cmd_valid = 1'b1;
      bus.wr_valid = (wr_from == 0) && len != 4'd0; bus.wr_data = wbuf[0];
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0; bus.cmd_addr = ~a; bus.cmd_rw = ~rw; bus.cmd_len = ~len;
      lat = 1;
      while (!bus.done && lat < 5000) begin
         @(posedge clk); #1;
         lat++;
         if (bus.wr_ready) begin wr_cnt++; wi++; end
         if (bus.rd_valid && rd_cnt < 16) begin rd_got[rd_cnt] = bus.rd_data; rd_cnt++; end
         if (lat == 100) begin mid_ready = bus.cmd_ready; mid_busy = bus.busy; end
         if (lat >= 330 && lat <= 420 && !bus.scl_oe) scl_rel++;
         bus.wr_valid = (lat >= wr_from) && (wi < int'(len));
         bus.wr_data = wbuf[wi % 16];
         stretch = st_from > 0 && lat >= st_from && lat < st_from + 50;
      end
      bus.wr_valid = 1'b0; stretch = 1'b0;
   endtask

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_addr = 7'd0; bus.cmd_rw = 1'b0; bus.cmd_len = 4'd0;
      bus.wr_valid = 1'b0; bus.wr_data = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_scl_oe", bus.scl_oe, 0);
      chk("rst_sda_oe", bus.sda_oe, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_nack", bus.nack, 0);
      chk("rst_wr_ready", bus.wr_ready, 0);
      chk("rst_rd_valid", bus.rd_valid, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      // Write 0x50 len 1, data 0xA5, responder ACKs
      wbuf[0] = 8'hA5; resp_ack = 1'b1; resp_n = 1;
      do_cmd(7'h50, 1'b0, 4'd1, 0, 0);
      chk("t1_latency", lat, 641);
      chk("t1_addr_byte", mon_byte[0], 8'hA0);
      chk("t1_data_byte", mon_byte[1], 8'hA5);
      chk("t1_wr_ready_cnt", wr_cnt, 1);
      chk("t1_nack", bus.nack, 0);
      chk("t1_mid_cmd_ready", mid_ready, 0);
      chk("t1_mid_busy", mid_busy, 1);
      chk("t1_busy_at_done", bus.busy, 0);
      @(posedge clk); #1;
      chk("t1_done_pulse", bus.done, 0);
      chk("t1_cmd_ready_after", bus.cmd_ready, 1);
      // Write 0x50 len 2, nobody answers
      wbuf[0] = 8'h11; wbuf[1] = 8'h22; resp_ack = 1'b0; resp_n = 2;
      do_cmd(7'h50, 1'b0, 4'd2, 0, 0);
      chk("t2_latency", lat, 353);
      chk("t2_nack", bus.nack, 1);
      chk("t2_wr_ready_cnt", wr_cnt, 0);
      chk("t2_addr_byte", mon_byte[0], 8'hA0);
      @(posedge clk); #1;
      chk("t2_nack_sticky", bus.nack, 1);
      // Address-only probe, ACKed; nack clears at accept
      resp_ack = 1'b1; resp_n = 0;
      do_cmd(7'h50, 1'b0, 4'd0, 0, 0);
      chk("probe_latency", lat, 353);
      chk("probe_nack", bus.nack, 0);
      @(posedge clk); #1;
      // Read 0x51 len 2, responder returns 0x3C, 0xC3
      rbuf[0] = 8'h3C; rbuf[1] = 8'hC3; resp_ack = 1'b1; resp_n = 2;
      do_cmd(7'h51, 1'b1, 4'd2, 0, 0);
      chk("t3_latency", lat, 929);
      chk("t3_addr_byte", mon_byte[0], 8'hA3);
      chk("t3_rd_cnt", rd_cnt, 2);
      chk("t3_rd0", rd_got[0], 8'h3C);
      chk("t3_rd1", rd_got[1], 8'hC3);
      chk("t3_master_ack1", mon_ack[1], 0);
      chk("t3_master_nack2", mon_ack[2], 1);
      chk("t3_nack", bus.nack, 0);
      @(posedge clk); #1;
      chk("t3_rd_data_held", bus.rd_data, 8'hC3);
      // Write len 1 with wr_valid withheld until cycle 421 (100 extra clocks)
      wbuf[0] = 8'h5A; resp_ack = 1'b1; resp_n = 1;
      do_cmd(7'h50, 1'b0, 4'd1, 421, 0);
      chk("t4_latency", lat, 742);
      chk("t4_scl_released_in_stall", scl_rel, 0);
      chk("t4_data_byte", mon_byte[1], 8'h5A);
      chk("t4_wr_ready_cnt", wr_cnt, 1);
      @(posedge clk); #1;
      // Responder holds SCL low 50 clk during the ACK slot
      wbuf[0] = 8'hA5; resp_ack = 1'b1; resp_n = 1;
      do_cmd(7'h50, 1'b0, 4'd1, 0, 305);
`ifdef I2C_CLOCK_STRETCH_EN
      chk("t6_latency_stretched", lat > 641 && lat <= 691, 1);
`else
      chk("t6_latency_unchanged", lat, 641);
`endif
      @(posedge clk); #1;
      // Reset in the middle of address bit 3
      bus.cmd_addr = 7'h50; bus.cmd_rw = 1'b0; bus.cmd_len = 4'd1; bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      repeat (174) @(posedge clk);
      #1;
      chk("t5_pre_busy", bus.busy, 1);
      chk("t5_pre_scl_oe", bus.scl_oe, 1);
      chk("t5_pre_sda_oe", bus.sda_oe, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("t5_scl_oe", bus.scl_oe, 0);
      chk("t5_sda_oe", bus.sda_oe, 0);
      chk("t5_cmd_ready", bus.cmd_ready, 1);
      chk("t5_busy", bus.busy, 0);
      reset = 1'b0;
      done_cnt = 0;
      repeat (700) begin
         @(posedge clk); #1;
         if (bus.done) done_cnt++;
      end
      chk("t5_no_done", done_cnt, 0);
      chk("t5_idle_scl", bus.scl_oe, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
